// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs_pkg
//  Description : Shared definitions for the multi-cycle control unit.
//                Opcode encodings (6-bit base, zero-extended by users),
//                FSM state encodings, ALUOp / PCSrc / RegDst codes, and the
//                decoded-instruction record produced by mcu_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    // Opcode encodings
    localparam logic [5:0] c_OPC_ADD  = 6'b000000;
    localparam logic [5:0] c_OPC_ADDI = 6'b000001;
    localparam logic [5:0] c_OPC_SUB  = 6'b000010;
    localparam logic [5:0] c_OPC_ORI  = 6'b010000;
    localparam logic [5:0] c_OPC_AND  = 6'b010001;
    localparam logic [5:0] c_OPC_OR   = 6'b010010;
    localparam logic [5:0] c_OPC_MOVE = 6'b100000;
    localparam logic [5:0] c_OPC_SW   = 6'b100110;
    localparam logic [5:0] c_OPC_LW   = 6'b100111;
    localparam logic [5:0] c_OPC_BEQ  = 6'b110000;
    localparam logic [5:0] c_OPC_J    = 6'b111000;
    localparam logic [5:0] c_OPC_JR   = 6'b111001;
    localparam logic [5:0] c_OPC_JAL  = 6'b111010;
    localparam logic [5:0] c_OPC_HALT = 6'b111111;

    // FSM states. The halt hold reuses S_ID together with a separate
    // halted flag, so it is not a distinct encoding here.
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    // ALU operation codes
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_OR  = 3'b010;
    localparam logic [2:0] c_ALU_AND = 3'b100;

    // Next-PC source select
    localparam logic [1:0] c_PCSRC_PC4 = 2'b00;
    localparam logic [1:0] c_PCSRC_BR  = 2'b01;
    localparam logic [1:0] c_PCSRC_RS  = 2'b10;
    localparam logic [1:0] c_PCSRC_JMP = 2'b11;

    // Destination register select
    localparam logic [1:0] c_REGDST_R31 = 2'b00;
    localparam logic [1:0] c_REGDST_RT  = 2'b01;
    localparam logic [1:0] c_REGDST_RD  = 2'b10;

    // Instruction classes
    typedef enum logic [2:0] {
        CL_ALU  = 3'd0,
        CL_BR   = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_JMP  = 3'd4,
        CL_HALT = 3'd5,
        CL_ILL  = 3'd6
    } op_class_t;

    // Decoded instruction: everything the FSM and output logic need
    typedef struct packed {
        op_class_t   cls;
        logic [2:0]  aluop;
        logic        alusrcb;
        logic        extsel;
        logic [1:0]  regdst;
        logic [1:0]  jpcsrc;   // PCSrc driven in S_ID for jumps
        logic        is_jal;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control_unit_if
//  Description : Control-unit <-> datapath signal bundle.
//                master : control unit (drives control outputs)
//                slave  : datapath / environment (drives Op, zero)
//                Signals: Op, zero in; PCWre, IRWre, InsMemRW, RD, WR,
//                ALUSrcB, DBDataSrc, RegWre, ExtSel, WrRegDSrc, RegDst,
//                PCSrc, ALUOp, State, Halted, Illegal, Retired out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_cycle_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [OP_W-1:0]    Op;
    logic               zero;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               RD;
    logic               WR;
    logic               ALUSrcB;
    logic               DBDataSrc;
    logic               RegWre;
    logic               ExtSel;
    logic               WrRegDSrc;
    logic [1:0]         RegDst;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic [2:0]         State;
    logic               Halted;
    logic               Illegal;
    logic [CNT_W-1:0]   Retired;

    modport master (
        input  Op, zero,
        output PCWre, IRWre, InsMemRW, RD, WR, ALUSrcB, DBDataSrc, RegWre,
               ExtSel, WrRegDSrc, RegDst, PCSrc, ALUOp, State, Halted,
               Illegal, Retired
    );

    modport slave (
        output Op, zero,
        input  PCWre, IRWre, InsMemRW, RD, WR, ALUSrcB, DBDataSrc, RegWre,
               ExtSel, WrRegDSrc, RegDst, PCSrc, ALUOp, State, Halted,
               Illegal, Retired
    );
endinterface
`default_nettype wire

// File: rtl/mcu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_decode
//  Description : Combinational opcode decode. Classifies the opcode and
//                produces the per-instruction static control fields.
//                Ports: op (in, OP_W) - opcode; dec (out, dec_t) - record.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_decode
    import cpu_defs_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  wire logic [OP_W-1:0] op,
    output dec_t                 dec
);

    always_comb begin
        dec.cls     = CL_ILL;
        dec.aluop   = c_ALU_ADD;
        dec.alusrcb = 1'b0;
        dec.extsel  = 1'b0;
        dec.regdst  = c_REGDST_R31;
        dec.jpcsrc  = c_PCSRC_PC4;
        dec.is_jal  = 1'b0;
        // Encodings are 6-bit; wider opcodes must carry zeros above them.
        case (op)
            OP_W'(c_OPC_ADD): begin
                dec.cls    = CL_ALU;
                dec.regdst = c_REGDST_RD;
            end
            OP_W'(c_OPC_ADDI): begin
                dec.cls     = CL_ALU;
                dec.alusrcb = 1'b1;
                dec.extsel  = 1'b1;
                dec.regdst  = c_REGDST_RT;
            end
            OP_W'(c_OPC_SUB): begin
                dec.cls    = CL_ALU;
                dec.aluop  = c_ALU_SUB;
                dec.regdst = c_REGDST_RD;
            end
            OP_W'(c_OPC_ORI): begin
                dec.cls     = CL_ALU;
                dec.aluop   = c_ALU_OR;
                dec.alusrcb = 1'b1;
                dec.regdst  = c_REGDST_RT;
            end
            OP_W'(c_OPC_AND): begin
                dec.cls    = CL_ALU;
                dec.aluop  = c_ALU_AND;
                dec.regdst = c_REGDST_RD;
            end
            OP_W'(c_OPC_OR): begin
                dec.cls    = CL_ALU;
                dec.aluop  = c_ALU_OR;
                dec.regdst = c_REGDST_RD;
            end
            OP_W'(c_OPC_MOVE): begin
                dec.cls    = CL_ALU;
                dec.regdst = c_REGDST_RD;
            end
            OP_W'(c_OPC_SW): begin
                dec.cls     = CL_ST;
                dec.alusrcb = 1'b1;
                dec.extsel  = 1'b1;
            end
            OP_W'(c_OPC_LW): begin
                dec.cls     = CL_LD;
                dec.alusrcb = 1'b1;
                dec.extsel  = 1'b1;
                dec.regdst  = c_REGDST_RT;
            end
            OP_W'(c_OPC_BEQ): begin
                dec.cls    = CL_BR;
                dec.aluop  = c_ALU_SUB;
                dec.extsel = 1'b1;
            end
            OP_W'(c_OPC_J): begin
                dec.cls    = CL_JMP;
                dec.jpcsrc = c_PCSRC_JMP;
            end
            OP_W'(c_OPC_JR): begin
                dec.cls    = CL_JMP;
                dec.jpcsrc = c_PCSRC_RS;
            end
            OP_W'(c_OPC_JAL): begin
                dec.cls    = CL_JMP;
                dec.jpcsrc = c_PCSRC_JMP;
                dec.is_jal = 1'b1;
            end
            OP_W'(c_OPC_HALT): begin
                dec.cls = CL_HALT;
            end
            default: begin
                dec.cls = CL_ILL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control_unit
//  Description : Multi-cycle CPU control FSM with halt hold, illegal-opcode
//                flag and retired-instruction counter.
//                Ports: CLK (in) clock; Reset (in) async active-low reset;
//                bus (multi_cycle_control_unit_if.master) Op/zero in,
//                all control strobes, State, Halted, Illegal, Retired out.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control_unit
    import cpu_defs_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  wire logic                   CLK,
    input  wire logic                   Reset,
    multi_cycle_control_unit_if.master  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] r_retired;
    dec_t             w_dec;

    logic             w_pcwre;
    logic             w_irwre;
    logic             w_regwre;
    logic             w_rd;
    logic             w_wr;
    logic             w_dbdatasrc;
    logic             w_illegal;
    logic [1:0]       w_pcsrc;

    mcu_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .op  (bus.Op),
        .dec (w_dec)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IF;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The halt hold parks in S_ID with r_halted set;
    // only the asynchronous reset releases it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_halted_nxt = r_halted;
        if (!r_halted) begin
            case (r_state)
                S_IF:     w_state_nxt = S_ID;
                S_ID: begin
                    case (w_dec.cls)
                        CL_ALU:       w_state_nxt = S_EXE_AL;
                        CL_BR:        w_state_nxt = S_EXE_BR;
                        CL_LD, CL_ST: w_state_nxt = S_EXE_LS;
                        CL_HALT: begin
                            w_state_nxt  = S_ID;
                            w_halted_nxt = 1'b1;
                        end
                        default:      w_state_nxt = S_IF;
                    endcase
                end
                S_EXE_AL: w_state_nxt = S_WB_AL;
                S_EXE_BR: w_state_nxt = S_IF;
                S_EXE_LS: w_state_nxt = S_MEM;
                S_MEM:    w_state_nxt = (w_dec.cls == CL_LD) ? S_WB_LD : S_IF;
                S_WB_AL:  w_state_nxt = S_IF;
                S_WB_LD:  w_state_nxt = S_IF;
                default:  w_state_nxt = S_IF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-dependent strobes. Everything is forced idle in the halt hold.
    // During reset the state is S_IF, so only IRWre needs explicit gating.
    // ------------------------------------------------------------------
    always_comb begin
        w_pcwre     = 1'b0;
        w_irwre     = 1'b0;
        w_regwre    = 1'b0;
        w_rd        = 1'b1;
        w_wr        = 1'b1;
        w_dbdatasrc = 1'b0;
        w_illegal   = 1'b0;
        w_pcsrc     = c_PCSRC_PC4;
        if (!r_halted) begin
            case (r_state)
                S_IF: begin
                    w_irwre = Reset;
                end
                S_ID: begin
                    if (w_dec.cls == CL_JMP || w_dec.cls == CL_ILL) begin
                        w_pcwre = 1'b1;
                    end
                    w_pcsrc   = w_dec.jpcsrc;
                    w_regwre  = w_dec.is_jal;
                    w_illegal = (w_dec.cls == CL_ILL);
                end
                S_EXE_BR: begin
                    w_pcwre = 1'b1;
                    w_pcsrc = bus.zero ? c_PCSRC_BR : c_PCSRC_PC4;
                end
                S_MEM: begin
                    if (w_dec.cls == CL_LD) begin
                        w_rd = 1'b0;
                    end else begin
                        w_wr    = 1'b0;
                        w_pcwre = 1'b1;
                    end
                end
                S_WB_AL: begin
                    w_pcwre  = 1'b1;
                    w_regwre = 1'b1;
                end
                S_WB_LD: begin
                    w_pcwre     = 1'b1;
                    w_regwre    = 1'b1;
                    w_dbdatasrc = 1'b1;
                end
                default: begin
                    w_pcwre = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter: one count per PC update, wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_retired <= '0;
        end else if (w_pcwre) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output mapping. Static fields come straight from the decode so they
    // stay constant for the whole life of one instruction.
    // ------------------------------------------------------------------
    assign bus.PCWre     = w_pcwre;
    assign bus.IRWre     = w_irwre;
    assign bus.InsMemRW  = 1'b0;
    assign bus.RD        = w_rd;
    assign bus.WR        = w_wr;
    assign bus.ALUSrcB   = w_dec.alusrcb;
    assign bus.DBDataSrc = w_dbdatasrc;
    assign bus.RegWre    = w_regwre;
    assign bus.ExtSel    = w_dec.extsel;
    assign bus.WrRegDSrc = ~w_dec.is_jal;
    assign bus.RegDst    = w_dec.regdst;
    assign bus.PCSrc     = w_pcsrc;
    assign bus.ALUOp     = ALUOP_W'(w_dec.aluop);
    assign bus.State     = r_state;
    assign bus.Halted    = r_halted;
    assign bus.Illegal   = w_illegal;
    assign bus.Retired   = r_retired;

endmodule
`default_nettype wire
